// File: rtl/hazard_if.sv
// hazard_if: pipeline-side hazard inputs and the sequencing controls returned to the datapath.
interface hazard_if;
  logic [4:0]  ifid_rs;
  logic [4:0]  ifid_rt;
  logic        idex_memRead;
  logic [4:0]  idex_rt;
  logic        exmem_PCSrc;
  logic        mem_req;
  logic        mem_ready;
  logic        pc_write;
  logic        ifid_write;
  logic        ifid_flush;
  logic        idex_bubble;
  logic        exmem_bubble;
  logic        stage_hold;
  logic        err;
  logic [15:0] stall_count;
  logic [1:0]  state;
  modport master (
    output ifid_rs, ifid_rt, idex_memRead, idex_rt, exmem_PCSrc, mem_req, mem_ready,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, stage_hold, err, stall_count, state
  );
  modport slave (
    input  ifid_rs, ifid_rt, idex_memRead, idex_rt, exmem_PCSrc, mem_req, mem_ready,
    output pc_write, ifid_write, ifid_flush, idex_bubble, exmem_bubble, stage_hold, err, stall_count, state
  );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline sequencer for init drain, load-use stalls, branch flushes and memory waits.
module hazard_ctrl #(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  hazard_if.slave h
);
  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT, ERROR} state_t;
  localparam logic [3:0]  INIT_LAST = 4'(INIT_CYCLES - 1);
  localparam logic [15:0] TMO = 16'(MEM_TIMEOUT);
  state_t      state_q, state_d;
  logic [3:0]  init_q, init_d;
  logic [15:0] wait_q, wait_d, wait_n, stall_q, stall_d;
  logic        err_q, err_d;
  logic        lu, mw, run_dec, wait_cyc, br, timeout;
  // run_dec: cycles decoded as normal RUN, including the MEM_WAIT cycle where memory completes
  always_comb begin
    lu = h.idex_memRead && h.idex_rt != 5'd0 && (h.idex_rt == h.ifid_rs || h.idex_rt == h.ifid_rt);
    mw = h.mem_req && !h.mem_ready;
    run_dec = (state_q == RUN && !mw) || (state_q == MEM_WAIT && h.mem_ready);
    wait_cyc = (state_q == RUN && mw) || (state_q == MEM_WAIT && !h.mem_ready);
    br = run_dec && h.exmem_PCSrc;
    h.pc_write = run_dec && (h.exmem_PCSrc || !lu);
    h.ifid_write = run_dec && !h.exmem_PCSrc && !lu;
    h.ifid_flush = state_q == INIT || br;
    h.idex_bubble = state_q == INIT || (run_dec && (h.exmem_PCSrc || lu));
    h.exmem_bubble = state_q == INIT || br;
    h.stage_hold = wait_cyc || state_q == ERROR;
    h.err = err_q;
    h.stall_count = stall_q;
    h.state = state_q;
    wait_n = state_q == RUN ? 16'd1 : wait_q + 16'd1;
    timeout = wait_cyc && wait_n >= TMO;
    state_d = state_q == INIT ? (init_q == INIT_LAST ? RUN : INIT) :
              state_q == ERROR || timeout ? ERROR :
              wait_cyc ? MEM_WAIT : RUN;
    init_d = state_q == INIT ? init_q + 4'd1 : init_q;
    wait_d = wait_cyc ? wait_n : 16'd0;
    err_d = err_q || timeout;
    stall_d = (!h.pc_write && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      init_q <= '0;
      wait_q <= '0;
      stall_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q <= init_d;
      wait_q <= wait_d;
      stall_q <= stall_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and random checks of hazard_ctrl against a rule-level model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  logic [4:0] rs, rtf, idrt;
  logic memrd, br, req, rdy;
  hazard_if h();
  hazard_if ht();
  assign h.ifid_rs = rs;       assign ht.ifid_rs = rs;
  assign h.ifid_rt = rtf;      assign ht.ifid_rt = rtf;
  assign h.idex_memRead = memrd; assign ht.idex_memRead = memrd;
  assign h.idex_rt = idrt;     assign ht.idex_rt = idrt;
  assign h.exmem_PCSrc = br;   assign ht.exmem_PCSrc = br;
  assign h.mem_req = req;      assign ht.mem_req = req;
  assign h.mem_ready = rdy;    assign ht.mem_ready = rdy;
  hazard_ctrl dut (.clk(clk), .reset(reset), .h(h.slave));
  hazard_ctrl #(.MEM_TIMEOUT(5)) dut_t (.clk(clk), .reset(reset), .h(ht.slave));
  typedef struct packed {
    logic pcw, ifw, fl, ib, eb, hold, err;
    logic [15:0] sc;
    logic [1:0] st;
  } out_t;
  typedef struct {
    int mode, age, waited, stalls;
    bit err;
  } mdl_t;
  mdl_t m[2];
  out_t e[2], o[2];
  int tmo[2] = '{255, 5};
  int checks = 0, errors = 0;
  // mode follows the observable state code: 0 init, 1 run, 2 waiting on memory, 3 error
  function automatic out_t predict(mdl_t s);
    out_t r = '0;
    bit hz, waiting;
    hz = memrd && idrt != 0 && (idrt == rs || idrt == rtf);
    waiting = s.mode == 1 ? (req && !rdy) : !rdy;
    r.st = 2'(s.mode);
    r.err = s.err;
    r.sc = 16'(s.stalls);
    if (s.mode == 0) begin r.fl = 1; r.ib = 1; r.eb = 1; end
    else if (s.mode == 3 || waiting) r.hold = 1;
    else if (br) begin r.pcw = 1; r.fl = 1; r.ib = 1; r.eb = 1; end
    else if (hz) r.ib = 1;
    else begin r.pcw = 1; r.ifw = 1; end
    return r;
  endfunction
  function automatic mdl_t advance(mdl_t s, out_t r, int t);
    mdl_t n = s;
    if (reset) begin
      n.mode = 0; n.age = 0; n.waited = 0; n.stalls = 0; n.err = 0;
      return n;
    end
    n.stalls = r.pcw ? s.stalls : (s.stalls < 65535 ? s.stalls + 1 : 65535);
    if (s.mode == 0) begin
      n.age = s.age + 1;
      if (n.age == 4) n.mode = 1;
    end else if (s.mode != 3) begin
      if (r.hold) begin
        n.waited = s.mode == 1 ? 1 : s.waited + 1;
        n.mode = n.waited >= t ? 3 : 2;
        if (n.mode == 3) n.err = 1;
      end else begin
        n.mode = 1;
        n.waited = 0;
      end
    end
    return n;
  endfunction
  task automatic cycle();
    for (int i = 0; i < 2; i++) e[i] = predict(m[i]);
    @(negedge clk);
    o[0] = {h.pc_write, h.ifid_write, h.ifid_flush, h.idex_bubble, h.exmem_bubble, h.stage_hold, h.err, h.stall_count, h.state};
    o[1] = {ht.pc_write, ht.ifid_write, ht.ifid_flush, ht.idex_bubble, ht.exmem_bubble, ht.stage_hold, ht.err, ht.stall_count, ht.state};
    @(posedge clk);
    for (int i = 0; i < 2; i++) m[i] = advance(m[i], e[i], tmo[i]);
    #1;
  endtask
  task automatic idle();
    memrd = 0; idrt = 0; rs = 0; rtf = 0; br = 0; req = 0; rdy = 0;
  endtask
  task automatic do_reset();
    idle();
    reset = 1;
    cycle();
    reset = 0;
  endtask
  task automatic to_run();
    do_reset();
    repeat (4) cycle();
  endtask
  task automatic test_reset();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      cycle();
      checks++;
      if (o[0].st !== 2'd0 || o[0].pcw !== 1'b0 || o[0].fl !== 1'b1)
        begin errors++; $display("FAIL init_cycle%0d got st=%0d pcw=%b fl=%b want st=0 pcw=0 fl=1", k, o[0].st, o[0].pcw, o[0].fl); end
    end
    cycle();
    checks++;
    if (o[0].st !== 2'd1) begin errors++; $display("FAIL init_exit got st=%0d want 1", o[0].st); end
    checks++;
    if (o[0].sc !== 16'd4) begin errors++; $display("FAIL init_stalls got %0d want 4", o[0].sc); end
    checks++;
    if (o[0] !== e[0]) begin errors++; $display("FAIL init_model got %h want %h", o[0], e[0]); end
  endtask
  task automatic test_load_use();
    to_run();
    memrd = 1; idrt = 8; rs = 8;
    cycle();
    checks++;
    if ({o[0].pcw, o[0].ifw, o[0].ib} !== 3'b001) begin errors++; $display("FAIL lu_stall got pcw/ifw/ib=%b want 001", {o[0].pcw, o[0].ifw, o[0].ib}); end
    memrd = 0;
    cycle();
    checks++;
    if (o[0].pcw !== 1'b1 || o[0].sc !== 16'd5) begin errors++; $display("FAIL lu_release got pcw=%b sc=%0d want pcw=1 sc=5", o[0].pcw, o[0].sc); end
    memrd = 1; idrt = 0; rs = 0; rtf = 0;
    cycle();
    checks++;
    if (o[0].pcw !== 1'b1 || o[0].ib !== 1'b0) begin errors++; $display("FAIL lu_r0 got pcw=%b ib=%b want pcw=1 ib=0", o[0].pcw, o[0].ib); end
    memrd = 1; idrt = 5; rs = 5; rtf = 5;
    cycle();
    checks++;
    if (o[0] !== e[0] || o[0].pcw !== 1'b0) begin errors++; $display("FAIL lu_rs_eq_rt got %h want %h", o[0], e[0]); end
  endtask
  task automatic test_branch_lu();
    to_run();
    memrd = 1; idrt = 8; rtf = 8; br = 1;
    cycle();
    checks++;
    if ({o[0].pcw, o[0].fl, o[0].ib, o[0].eb} !== 4'b1111) begin errors++; $display("FAIL br_flush got pcw/fl/ib/eb=%b want 1111", {o[0].pcw, o[0].fl, o[0].ib, o[0].eb}); end
    idle();
    cycle();
    checks++;
    if (o[0].sc !== 16'd4) begin errors++; $display("FAIL br_nostall got sc=%0d want 4", o[0].sc); end
  endtask
  task automatic test_mem_wait();
    to_run();
    req = 1; rdy = 0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (o[0].hold !== 1'b1 || o[0].pcw !== 1'b0 || o[0].st !== (k == 0 ? 2'd1 : 2'd2))
        begin errors++; $display("FAIL mw_hold%0d got hold=%b pcw=%b st=%0d want hold=1 pcw=0 st=%0d", k, o[0].hold, o[0].pcw, o[0].st, k == 0 ? 1 : 2); end
    end
    rdy = 1; br = 1;
    cycle();
    checks++;
    if (o[0].hold !== 1'b0 || o[0].fl !== 1'b1 || o[0].st !== 2'd2) begin errors++; $display("FAIL mw_ready got hold=%b fl=%b st=%0d want 0 1 2", o[0].hold, o[0].fl, o[0].st); end
    idle();
    cycle();
    checks++;
    if (o[0].st !== 2'd1) begin errors++; $display("FAIL mw_return got st=%0d want 1", o[0].st); end
  endtask
  task automatic test_timeout();
    to_run();
    req = 1; rdy = 0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      checks++;
      if (o[1].hold !== 1'b1 || o[1].err !== 1'b0 || o[1].st !== (k == 0 ? 2'd1 : 2'd2))
        begin errors++; $display("FAIL tmo_wait%0d got hold=%b err=%b st=%0d", k, o[1].hold, o[1].err, o[1].st); end
    end
    rdy = 1; br = 1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (o[1].st !== 2'd3 || o[1].err !== 1'b1 || o[1].hold !== 1'b1 || o[1].pcw !== 1'b0 || o[1].fl !== 1'b0)
        begin errors++; $display("FAIL tmo_error%0d got st=%0d err=%b hold=%b pcw=%b fl=%b want 3 1 1 0 0", k, o[1].st, o[1].err, o[1].hold, o[1].pcw, o[1].fl); end
    end
    do_reset();
    cycle();
    checks++;
    if (o[1].st !== 2'd0 || o[1].err !== 1'b0) begin errors++; $display("FAIL tmo_reset got st=%0d err=%b want 0 0", o[1].st, o[1].err); end
  endtask
  task automatic test_reset_mid_wait();
    to_run();
    req = 1; rdy = 0;
    repeat (3) cycle();
    reset = 1;
    cycle();
    reset = 0;
    idle();
    cycle();
    checks++;
    if (o[0].st !== 2'd0 || o[0].sc !== 16'd0 || o[0].err !== 1'b0) begin errors++; $display("FAIL mid_reset got st=%0d sc=%0d err=%b want 0 0 0", o[0].st, o[0].sc, o[0].err); end
  endtask
  task automatic test_random();
    to_run();
    for (int n = 0; n < 600; n++) begin
      reset = $urandom_range(99) < 2;
      memrd = $urandom_range(1); idrt = 5'($urandom_range(3));
      rs = 5'($urandom_range(3)); rtf = 5'($urandom_range(3));
      br = $urandom_range(3) == 0; req = $urandom_range(1); rdy = $urandom_range(9) < 7;
      cycle();
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (o[i] !== e[i]) begin errors++; $display("FAIL rand%0d inst%0d got %h want %h", n, i, o[i], e[i]); end
      end
    end
    reset = 0;
  endtask
  task automatic test_saturate();
    to_run();
    req = 1; rdy = 0;
    repeat (70000) cycle();
    checks++;
    if (o[0].sc !== 16'hFFFF || e[0].sc !== 16'hFFFF) begin errors++; $display("FAIL saturate got %0d want 65535", o[0].sc); end
  endtask
  initial begin
    idle();
    test_reset();
    test_load_use();
    test_branch_lu();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
